// File: rtl/tick_event_gen.sv
// tick_event_gen: divides upstream ticks into sequenced valid/ready events,
// counts events dropped by a busy consumer and flags a sticky tick-gap stall.
module tick_event_gen #(
   parameter int DIV     = 4,
   parameter int DBITS   = 3,
   parameter int TIMEOUT = 20000,
   parameter int TBITS   = 15,
   parameter int OBITS   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             en,
   input  logic             evt_ready,
   output logic             evt_valid,
   output logic [7:0]       evt_seq,
   output logic [OBITS-1:0] ovr_cnt,
   output logic             stall,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
   state_t state, state_nx;
   logic [DBITS-1:0] div;
   logic [TBITS-1:0] gap;
   logic [7:0] seq_next;
   logic due, load, drop;
   assign due  = en && tick && (div == DBITS'(DIV - 1));
   // a due lands in the output slot unless an unaccepted event still occupies it
   assign load = due && (state != PEND || evt_ready);
   assign drop = due && state == PEND && !evt_ready;
   assign evt_valid = state == PEND;
   assign busy      = state != IDLE;
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_nx;
   always_comb begin
      state_nx = load ? PEND : (state == PEND && !evt_ready) ? PEND : en ? RUN : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         div      <= '0;
         gap      <= '0;
         seq_next <= '0;
         evt_seq  <= '0;
         ovr_cnt  <= '0;
         stall    <= 1'b0;
      end else begin
         div      <= !en ? '0 : !tick ? div : due ? '0 : div + 1'b1;
         gap      <= (!en || tick) ? '0 : (gap == '1) ? gap : gap + 1'b1;
         seq_next <= seq_next + 8'(due);
         evt_seq  <= load ? seq_next : evt_seq;
         ovr_cnt  <= (drop && ovr_cnt != '1) ? ovr_cnt + 1'b1 : ovr_cnt;
         stall    <= stall || gap >= TBITS'(TIMEOUT);
      end
   end
endmodule

// File: tb/tb_tick_event_gen.sv
// tb_tick_event_gen: directed steps with a scoreboard of expected event sequence numbers.
module tb_tick_event_gen;
   logic clk = 1'b0;
   logic rst, tick, en, evt_ready;
   logic evt_valid, stall, busy;
   logic [7:0] evt_seq, ovr_cnt;
   int n_chk = 0, n_fail = 0;
   int mdiv, mseq, movr;
   int q[$];

   tick_event_gen #(.DIV(4), .DBITS(3), .TIMEOUT(20), .TBITS(15), .OBITS(8)) dut (
      .clk(clk), .rst(rst), .tick(tick), .en(en), .evt_ready(evt_ready),
      .evt_valid(evt_valid), .evt_seq(evt_seq), .ovr_cnt(ovr_cnt), .stall(stall), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one clock: score the handshake about to complete, model the due, then advance
   task automatic step(input logic t);
      tick = t;
      if (!rst) begin
         chk("valid_vs_model", 32'(evt_valid), 32'(q.size() != 0));
         if (evt_valid && evt_ready && q.size() != 0)
            chk("accept_seq", 32'(evt_seq), 32'(q.pop_front()));
         if (!en) mdiv = 0;
         else if (t) begin
            mdiv++;
            if (mdiv == 4) begin
               mdiv = 0;
               if (q.size() != 0) movr = (movr == 255) ? 255 : movr + 1;
               else q.push_back(mseq);
               mseq = (mseq + 1) % 256;
            end
         end
      end
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic ticks(input int n, input int spacing);
      for (int i = 0; i < n; i++) begin
         step(1'b1);
         for (int j = 1; j < spacing; j++) step(1'b0);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en = 1'b0;
      step(1'b0);
      step(1'b0);
      rst = 1'b0;
      q.delete();
      mdiv = 0;
      mseq = 0;
      movr = 0;
   endtask

   initial begin
      rst = 1'b1; tick = 1'b0; en = 1'b0; evt_ready = 1'b1;
      do_reset();
      chk("rst_valid", 32'(evt_valid), 0);
      chk("rst_seq", 32'(evt_seq), 0);
      chk("rst_ovr", 32'(ovr_cnt), 0);
      chk("rst_stall", 32'(stall), 0);
      chk("rst_busy", 32'(busy), 0);

      // normal flow, consumer always ready
      en = 1'b1;
      step(1'b0);
      chk("t1_busy", 32'(busy), 1);
      ticks(16, 5);
      chk("t1_drained", 32'(q.size()), 0);
      chk("t1_seq_last", 32'(evt_seq), 3);
      chk("t1_ovr", 32'(ovr_cnt), 0);
      chk("t1_stall", 32'(stall), 0);

      // consumer stalls across 12 ticks: two drops
      do_reset();
      en = 1'b1; evt_ready = 1'b0;
      ticks(12, 5);
      chk("t2_valid", 32'(evt_valid), 1);
      chk("t2_seq_held", 32'(evt_seq), 0);
      chk("t2_ovr", 32'(ovr_cnt), 2);
      chk("t2_ovr_model", 32'(ovr_cnt), 32'(movr));
      evt_ready = 1'b1;
      step(1'b0);
      chk("t2_released", 32'(evt_valid), 0);
      ticks(4, 5);
      chk("t2_next_seq", 32'(evt_seq), 3);

      // ready arrives on the same edge as the next due: no drop
      do_reset();
      en = 1'b1; evt_ready = 1'b0;
      ticks(7, 5);
      chk("t3_pending", 32'(evt_seq), 0);
      evt_ready = 1'b1;
      step(1'b1);
      chk("t3_valid", 32'(evt_valid), 1);
      chk("t3_seq", 32'(evt_seq), 1);
      chk("t3_ovr", 32'(ovr_cnt), 0);
      step(1'b0);
      chk("t3_done", 32'(evt_valid), 0);

      // watchdog
      do_reset();
      en = 1'b1;
      for (int i = 0; i < 20; i++) step(1'b0);
      chk("t4_no_stall_yet", 32'(stall), 0);
      step(1'b0);
      chk("t4_stall", 32'(stall), 1);
      ticks(5, 2);
      chk("t4_sticky", 32'(stall), 1);
      do_reset();
      chk("t4_rst_clear", 32'(stall), 0);

      // pending event survives en=0; divider restarts from 0
      en = 1'b1; evt_ready = 1'b0;
      ticks(6, 3);
      en = 1'b0;
      ticks(2, 3);
      chk("t5_held_valid", 32'(evt_valid), 1);
      chk("t5_held_busy", 32'(busy), 1);
      evt_ready = 1'b1;
      step(1'b0);
      chk("t5_idle_valid", 32'(evt_valid), 0);
      chk("t5_idle_busy", 32'(busy), 0);
      ticks(8, 2);
      chk("t5_ignored", 32'(evt_valid), 0);
      en = 1'b1;
      ticks(3, 2);
      chk("t5_div_cleared", 32'(evt_valid), 0);
      step(1'b1);
      chk("t5_new_evt", 32'(evt_valid), 1);
      chk("t5_new_seq", 32'(evt_seq), 1);
      step(1'b0);

      // overrun saturation, then reset mid-handshake
      do_reset();
      en = 1'b1; evt_ready = 1'b0;
      ticks(4 + 300 * 4, 1);
      chk("t6_sat", 32'(ovr_cnt), 255);
      chk("t6_sat_model", 32'(ovr_cnt), 32'(movr));
      chk("t6_valid", 32'(evt_valid), 1);
      rst = 1'b1;
      step(1'b0);
      chk("t6_rst_valid", 32'(evt_valid), 0);
      chk("t6_rst_seq", 32'(evt_seq), 0);
      chk("t6_rst_ovr", 32'(ovr_cnt), 0);
      chk("t6_rst_stall", 32'(stall), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      do_reset();
      en = 1'b1; evt_ready = 1'b1;
      ticks(4, 2);
      chk("t6_first_seq", 32'(evt_seq), 0);
      chk("t6_drained", 32'(q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
